// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the data-memory bus arbiter.
package mem_arb_pkg;

    localparam int DEF_NREQ = 4;
    localparam int DEF_IDW  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURNA = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Request/grant bundle between the bus masters and the arbiter.
interface mem_bus_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IDW  = DEF_IDW
);
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] grt;
    logic [IDW-1:0]  owner;
    logic            owner_vld;
    logic            hold_err;
    logic [IDW-1:0]  err_id;

    modport master (
        output req,
        input  grt, owner, owner_vld, hold_err, err_id
    );

    modport slave (
        input  req,
        output grt, owner, owner_vld, hold_err, err_id
    );
endinterface

// File: rtl/mem_rr_pick.sv
// Combinational round-robin pick: first set req bit at or above rr_ptr, wrapping.
module mem_rr_pick
    import mem_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IDW  = DEF_IDW
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  rr_ptr,
    output logic [IDW-1:0]  pick,
    output logic            any
);
    logic [NREQ-1:0] rot;
    logic [IDW-1:0]  enc;

    // NREQ need not be a power of two, so wrap by conditional subtract.
    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] a,
                                                input logic [IDW-1:0] b);
        logic [IDW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= (IDW+1)'(NREQ))
            s = s - (IDW+1)'(NREQ);
        return s[IDW-1:0];
    endfunction

    always_comb begin
        rot = '0;
        for (int i = 0; i < NREQ; i++)
            rot[i] = req[wrap_add(rr_ptr, IDW'(i))];
    end

    always_comb begin
        enc = '0;
        for (int i = NREQ-1; i >= 0; i--)
            if (rot[i])
                enc = IDW'(i);
    end

    assign pick = wrap_add(rr_ptr, enc);
    assign any  = |req;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin owner of the shared data-memory bus: non-preemptive grants,
// programmable turnaround after each release, sticky over-long-hold flag.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int IDW     = DEF_IDW,
    parameter int TURN    = 1,
    parameter int MAXHOLD = 64
) (
    input  logic            clk,
    input  logic            rst,
    mem_bus_arbiter_if.slave bus
);
    localparam logic [7:0] MAXH      = 8'(MAXHOLD);
    localparam logic [1:0] TURN_INIT = (TURN > 0) ? 2'(TURN - 1) : 2'd0;

    arb_state_t      state;
    logic [NREQ-1:0] grt_q;
    logic [IDW-1:0]  owner_q;
    logic            vld_q;
    logic [IDW-1:0]  rr_ptr;
    logic [7:0]      hold_cnt;
    logic [1:0]      turn_cnt;
    logic            hold_err_q;
    logic [IDW-1:0]  err_id_q;

    logic [IDW-1:0]  pick;
    logic            any;
    logic [NREQ-1:0] pick_oh;

    mem_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req    (bus.req),
        .rr_ptr (rr_ptr),
        .pick   (pick),
        .any    (any)
    );

    always_comb begin
        pick_oh       = '0;
        pick_oh[pick] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grt_q      <= '0;
            owner_q    <= '0;
            vld_q      <= 1'b0;
            rr_ptr     <= '0;
            hold_cnt   <= '0;
            turn_cnt   <= '0;
            hold_err_q <= 1'b0;
            err_id_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any) begin
                        grt_q    <= pick_oh;
                        owner_q  <= pick;
                        vld_q    <= 1'b1;
                        rr_ptr   <= (pick == IDW'(NREQ - 1)) ? '0 : pick + IDW'(1);
                        hold_cnt <= '0;
                        state    <= GRANT;
                    end else begin
                        grt_q <= '0;
                    end
                end
                GRANT: begin
                    if (bus.req[owner_q]) begin
                        if (hold_cnt != MAXH)
                            hold_cnt <= hold_cnt + 8'd1;
                        // Only the first offender is recorded until reset.
                        if (!hold_err_q && hold_cnt == MAXH - 8'd1) begin
                            hold_err_q <= 1'b1;
                            err_id_q   <= owner_q;
                        end
                    end else begin
                        grt_q    <= '0;
                        vld_q    <= 1'b0;
                        hold_cnt <= '0;
                        if (TURN > 0) begin
                            turn_cnt <= TURN_INIT;
                            state    <= TURNA;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                TURNA: begin
                    if (turn_cnt == 2'd0)
                        state <= IDLE;
                    else
                        turn_cnt <= turn_cnt - 2'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.grt       = grt_q;
    assign bus.owner     = owner_q;
    assign bus.owner_vld = vld_q;
    assign bus.hold_err  = hold_err_q;
    assign bus.err_id    = err_id_q;

endmodule
